// File: rtl/button_counter_4bit.sv
`default_nettype none
// ============================================================================
//  Module   : button_counter_4bit
//  Purpose  : Debounces a start/stop and a clear pushbutton and runs a
//             prescaled single-digit up/down counter (IDLE / RUN / PAUSE)
//             that feeds the 4-bit digit input of the seven-segment driver.
//  Ports    : sys_clk   - system clock
//             reset     - asynchronous, active-high reset
//             btn_start - raw start/stop button (async, active-high)
//             btn_clear - raw clear button (async, active-high)
//             dir_up    - direction switch, 1 = up, 0 = down (async)
//             Count_Out - registered count value, 0..MAX_VALUE
//             Carry_Out - one-cycle pulse on wrap in either direction
//             Run_Led   - high exactly while the FSM is in RUN
//  Revision : 1.0 - initial release
// ============================================================================
module button_counter_4bit #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int TICK_CYCLES     = 100000000,
    parameter int MAX_VALUE       = 15
) (
    input  logic       sys_clk,
    input  logic       reset,
    input  logic       btn_start,
    input  logic       btn_clear,
    input  logic       dir_up,
    output logic [3:0] Count_Out,
    output logic       Carry_Out,
    output logic       Run_Led
);

    localparam int              c_DW       = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int              c_PW       = $clog2(TICK_CYCLES);
    localparam logic [c_DW-1:0] c_DEB_LAST = c_DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_PW-1:0] c_TICK_LAST = c_PW'(TICK_CYCLES - 1);
    localparam logic [3:0]      c_MAX      = 4'(MAX_VALUE);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Button synchronizers, debouncers and press detectors.
    // Index 0 = start, index 1 = clear.
    // ------------------------------------------------------------------
    logic [1:0] w_btn_raw;
    logic [1:0] w_press;

    assign w_btn_raw = {btn_clear, btn_start};

    for (genvar gi = 0; gi < 2; gi++) begin : g_debounce
        logic            r_s1;
        logic            r_s2;
        logic            r_level;
        logic            r_press;
        logic [c_DW-1:0] r_cnt;

        always_ff @(posedge sys_clk or posedge reset) begin
            if (reset) begin
                r_s1    <= 1'b0;
                r_s2    <= 1'b0;
                r_level <= 1'b0;
                r_press <= 1'b0;
                r_cnt   <= '0;
            end else begin
                r_s1    <= w_btn_raw[gi];
                r_s2    <= r_s1;
                r_press <= 1'b0;
                if (r_s2 == r_level) begin
                    r_cnt <= '0;
                end else if (r_cnt == c_DEB_LAST) begin
                    // Accept the new level; the press pulse is issued in the
                    // same edge so it lines up with the level change itself.
                    r_level <= r_s2;
                    r_press <= r_s2;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + c_DW'(1);
                end
            end
        end

        assign w_press[gi] = r_press;
    end

    logic w_start_p;
    logic w_clear_p;

    assign w_start_p = w_press[0];
    assign w_clear_p = w_press[1];

    // Direction switch only needs synchronizing; it is sampled on ticks.
    logic r_dir_s1;
    logic r_dir_s2;

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            r_dir_s1 <= 1'b0;
            r_dir_s2 <= 1'b0;
        end else begin
            r_dir_s1 <= dir_up;
            r_dir_s2 <= r_dir_s1;
        end
    end

    // ------------------------------------------------------------------
    // Control FSM and counter datapath
    // ------------------------------------------------------------------
    state_t          r_state;
    state_t          w_state_next;
    logic [c_PW-1:0] r_presc;
    logic [c_PW-1:0] w_presc_next;
    logic [3:0]      r_count;
    logic [3:0]      w_count_next;
    logic            r_carry;
    logic            w_carry_next;
    logic            r_run_led;
    logic            w_tick;

    assign w_tick = (r_state == S_RUN) && (r_presc == c_TICK_LAST);

    always_comb begin
        w_state_next = r_state;
        w_presc_next = r_presc;
        w_count_next = r_count;
        w_carry_next = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_presc_next = '0;
                w_count_next = 4'd0;
                if (w_start_p) begin
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (w_tick) begin
                    w_presc_next = '0;
                    if (r_dir_s2) begin
                        if (r_count == c_MAX) begin
                            w_count_next = 4'd0;
                            w_carry_next = 1'b1;
                        end else begin
                            w_count_next = r_count + 4'd1;
                        end
                    end else begin
                        if (r_count == 4'd0) begin
                            w_count_next = c_MAX;
                            w_carry_next = 1'b1;
                        end else begin
                            w_count_next = r_count - 4'd1;
                        end
                    end
                end else begin
                    w_presc_next = r_presc + c_PW'(1);
                end
                if (w_start_p) begin
                    w_state_next = S_PAUSE;
                end
            end
            S_PAUSE: begin
                // Prescaler and count hold, so a resume continues mid-period.
                if (w_start_p) begin
                    w_state_next = S_RUN;
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_presc_next = '0;
                w_count_next = 4'd0;
            end
        endcase

        // Clear overrides everything, including a simultaneous start press.
        if (w_clear_p) begin
            w_state_next = S_IDLE;
            w_presc_next = '0;
            w_count_next = 4'd0;
            w_carry_next = 1'b0;
        end
    end

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_presc   <= '0;
            r_count   <= 4'd0;
            r_carry   <= 1'b0;
            r_run_led <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_presc   <= w_presc_next;
            r_count   <= w_count_next;
            r_carry   <= w_carry_next;
            // Registered from the next state so the LED tracks RUN exactly.
            r_run_led <= (w_state_next == S_RUN);
        end
    end

    assign Count_Out = r_count;
    assign Carry_Out = r_carry;
    assign Run_Led   = r_run_led;

endmodule
`default_nettype wire

// File: tb/tb_button_counter_4bit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_button_counter_4bit
//  Purpose  : Self-checking bench for button_counter_4bit. Expected output
//             changes are queued by the stimulus; a monitor pops and compares
//             them (value and cycle spacing) whenever the outputs change.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_button_counter_4bit;

    localparam int DEB  = 4;
    localparam int TICK = 5;
    localparam int MAXV = 9;

    logic       sys_clk   = 1'b0;
    logic       reset     = 1'b1;
    logic       btn_start = 1'b0;
    logic       btn_clear = 1'b0;
    logic       dir_up    = 1'b1;
    logic [3:0] Count_Out;
    logic       Carry_Out;
    logic       Run_Led;

    button_counter_4bit #(
        .DEBOUNCE_CYCLES (DEB),
        .TICK_CYCLES     (TICK),
        .MAX_VALUE       (MAXV)
    ) dut (
        .sys_clk   (sys_clk),
        .reset     (reset),
        .btn_start (btn_start),
        .btn_clear (btn_clear),
        .dir_up    (dir_up),
        .Count_Out (Count_Out),
        .Carry_Out (Carry_Out),
        .Run_Led   (Run_Led)
    );

    always #5 sys_clk = ~sys_clk;

    // Rising-edge counter; read at negedges, where it equals the index of
    // the most recent rising edge.
    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    // Expected events: {Run_Led, Count_Out, Carry_Out} and the required
    // number of edges since the previous change (-1 = not checked).
    logic [5:0] exp_q[$];
    int         gap_q[$];

    task automatic push(input logic led, input logic [3:0] c, input logic cy, input int gap);
        exp_q.push_back({led, c, cy});
        gap_q.push_back(gap);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) @(negedge sys_clk);
    endtask

    // ---------------------------------------------------------------- monitor
    logic [5:0] mon_prev = 6'd0;
    logic [5:0] mon_now;
    logic [5:0] mon_exp;
    int         mon_gap;
    int         mon_req_gap;
    int         mon_last = 0;

    always @(negedge sys_clk) begin
        mon_now = {Run_Led, Count_Out, Carry_Out};
        if (mon_now !== mon_prev) begin
            mon_gap = cyc - mon_last;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_event: got led=%0b count=%0d carry=%0b, none expected (cycle %0d)",
                         Run_Led, Count_Out, Carry_Out, cyc);
            end else begin
                mon_exp     = exp_q.pop_front();
                mon_req_gap = gap_q.pop_front();
                check("event_value{led,count,carry}", 32'(mon_now), 32'(mon_exp));
                if (mon_req_gap >= 0) check("event_spacing", mon_gap, mon_req_gap);
            end
            mon_prev = mon_now;
            mon_last = cyc;
        end
    end

    // ---------------------------------------------------------------- watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // ---------------------------------------------------------------- stimulus
    int k;
    int lat;
    int t0;
    int pause_edge;
    int resume_edge;
    int s_edge;
    int e2;

    initial begin
        // Reset state
        repeat (3) @(negedge sys_clk);
        check("reset_count", Count_Out, 0);
        check("reset_carry", Carry_Out, 0);
        check("reset_led", Run_Led, 0);
        reset = 1'b0;
        repeat (3) @(negedge sys_clk);

        // Bounce: 2 high, 3 low, 2 high -> nothing happens
        btn_start = 1'b1; repeat (2) @(negedge sys_clk);
        btn_start = 1'b0; repeat (3) @(negedge sys_clk);
        btn_start = 1'b1; repeat (2) @(negedge sys_clk);
        btn_start = 1'b0; repeat (12) @(negedge sys_clk);
        check("bounce_led", Run_Led, 0);

        // Up count 0..9,0 then 1,2,3, then pause two edges into the period
        push(1'b1, 4'd0, 1'b0, -1);
        for (int v = 1; v <= 9; v++) push(1'b1, 4'(v), 1'b0, 5);
        push(1'b1, 4'd0, 1'b1, 5);
        push(1'b1, 4'd0, 1'b0, 1);
        push(1'b1, 4'd1, 1'b0, 4);
        push(1'b1, 4'd2, 1'b0, 5);
        push(1'b1, 4'd3, 1'b0, 5);
        push(1'b0, 4'd3, 1'b0, 2);

        btn_start = 1'b1;
        k = 0;
        while (Run_Led !== 1'b1 && k < 20) begin
            @(negedge sys_clk);
            k++;
        end
        total++;
        if (k < 6 || k > 8) begin
            bad++;
            $display("FAIL press_latency: got %0d cycles expected 6..8", k);
        end
        lat = (k >= 6 && k <= 8) ? k : 7;
        t0  = cyc;
        repeat ((k < 10) ? 10 - k : 0) @(negedge sys_clk);
        btn_start = 1'b0;

        // Pause so the state changes on edge t0+67 (prescaler held at 2)
        wait_until(t0 + 67 - lat);
        btn_start = 1'b1; repeat (10) @(negedge sys_clk);
        btn_start = 1'b0;
        pause_edge = t0 + 67;
        wait_until(pause_edge + 50);
        check("pause_count_hold", Count_Out, 3);
        check("pause_led", Run_Led, 0);

        // Resume: step to 4 three edges after RUN re-entry, then 5, 6,
        // then start+clear together while at 6 -> IDLE directly
        push(1'b1, 4'd3, 1'b0, -1);
        push(1'b1, 4'd4, 1'b0, 3);
        push(1'b1, 4'd5, 1'b0, 5);
        push(1'b1, 4'd6, 1'b0, 5);
        push(1'b0, 4'd0, 1'b0, -1);
        btn_start = 1'b1; repeat (10) @(negedge sys_clk);
        btn_start = 1'b0;
        resume_edge = pause_edge + 50 + lat;
        wait_until(resume_edge + 9);
        btn_start = 1'b1;
        btn_clear = 1'b1;
        repeat (10) @(negedge sys_clk);
        btn_start = 1'b0;
        btn_clear = 1'b0;
        repeat (4) @(negedge sys_clk);
        check("clear_count", Count_Out, 0);
        check("clear_led", Run_Led, 0);
        repeat (10) @(negedge sys_clk);

        // Down count from 0: wrap to 9 with carry, then 8,7,6,5
        dir_up = 1'b0;
        repeat (4) @(negedge sys_clk);
        push(1'b1, 4'd0, 1'b0, -1);
        push(1'b1, 4'd9, 1'b1, 5);
        push(1'b1, 4'd9, 1'b0, 1);
        push(1'b1, 4'd8, 1'b0, 4);
        push(1'b1, 4'd7, 1'b0, 5);
        push(1'b1, 4'd6, 1'b0, 5);
        push(1'b1, 4'd5, 1'b0, 5);
        push(1'b0, 4'd0, 1'b0, -1);
        s_edge = cyc + lat;
        btn_start = 1'b1; repeat (10) @(negedge sys_clk);
        btn_start = 1'b0;

        // Asynchronous reset between edges while the count is 5
        wait_until(s_edge + 27);
        @(posedge sys_clk);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_count", Count_Out, 0);
        check("async_reset_carry", Carry_Out, 0);
        check("async_reset_led", Run_Led, 0);
        dir_up = 1'b1;
        repeat (3) @(negedge sys_clk);
        reset = 1'b0;
        repeat (2) @(negedge sys_clk);

        // Fresh press after reset: full debounce, first step 5 edges later
        push(1'b1, 4'd0, 1'b0, -1);
        push(1'b1, 4'd1, 1'b0, 5);
        btn_start = 1'b1;
        k = 0;
        while (Run_Led !== 1'b1 && k < 20) begin
            @(negedge sys_clk);
            k++;
        end
        check("post_reset_latency", k, lat);
        e2 = cyc;
        repeat ((k < 10) ? 10 - k : 0) @(negedge sys_clk);
        btn_start = 1'b0;
        wait_until(e2 + 8);
        check("post_reset_count", Count_Out, 1);

        @(negedge sys_clk);
        check("pending_events", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
